// File: rtl/wam_pkg.sv
// Shared definitions for the window alarm monitor: FSM state encoding and
// default sizing constants.
package wam_pkg;

  localparam int W_DEF        = 8;
  localparam int DEBOUNCE_DEF = 3;
  localparam int CNT_W_DEF    = 8;
  localparam int RUN_W        = 4;   // holds a run length up to 15

  typedef enum logic [2:0] {
    ST_OK       = 3'd0,
    ST_PEND_HI  = 3'd1,
    ST_PEND_LO  = 3'd2,
    ST_ALARM_HI = 3'd3,
    ST_ALARM_LO = 3'd4
  } state_e;

endpackage

// File: rtl/mag_cmp_w.sv
// Combinational W-bit unsigned magnitude comparator (a versus b).
module mag_cmp_w #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt,
  output logic         eq,
  output logic         gt
);

  assign lt = (a <  b);
  assign eq = (a == b);
  assign gt = (a >  b);

endmodule

// File: rtl/window_alarm_monitor.sv
// Compares a sample stream against programmable thresholds, debounces
// out-of-window runs into sticky alarms and counts alarm entries.
module window_alarm_monitor
  import wam_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [W-1:0]     cfg_lo,
  input  logic [W-1:0]     cfg_hi,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic             res_above,
  output logic             res_below,
  output logic             alarm_hi,
  output logic             alarm_lo,
  output logic             cfg_err,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] viol_cnt
);

  localparam logic [RUN_W-1:0] DB = RUN_W'(DEBOUNCE);

  logic [W-1:0]     r_lo;
  logic [W-1:0]     r_hi;
  logic             r_cfg_err;
  logic             r_out_valid;
  logic             r_res_above;
  logic             r_res_below;
  state_e           r_state;
  logic [RUN_W-1:0] r_run;
  logic [CNT_W-1:0] r_viol;

  logic w_accept;
  logic w_hi_lt, w_hi_eq, w_hi_gt;
  logic w_lo_lt, w_lo_eq, w_lo_gt;
  logic w_above, w_below, w_inside;
  logic [RUN_W-1:0] w_run_inc;

  mag_cmp_w #(.W(W)) u_cmp_hi (
    .a  (in_data),
    .b  (r_hi),
    .lt (w_hi_lt),
    .eq (w_hi_eq),
    .gt (w_hi_gt)
  );

  mag_cmp_w #(.W(W)) u_cmp_lo (
    .a  (in_data),
    .b  (r_lo),
    .lt (w_lo_lt),
    .eq (w_lo_eq),
    .gt (w_lo_gt)
  );

  // Configuration writes take priority, so a sample offered alongside stalls.
  assign in_ready  = !cfg_wr && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_above   = w_hi_gt;
  assign w_below   = w_lo_lt;
  assign w_inside  = (w_lo_gt || w_lo_eq) && (w_hi_lt || w_hi_eq);
  assign w_run_inc = r_run + RUN_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lo        <= '0;
      r_hi        <= '1;
      r_cfg_err   <= 1'b0;
      r_out_valid <= 1'b0;
      r_res_above <= 1'b0;
      r_res_below <= 1'b0;
      r_state     <= ST_OK;
      r_run       <= '0;
      r_viol      <= '0;
    end else begin
      r_out_valid <= w_accept;

      if (cfg_wr) begin
        r_lo      <= cfg_lo;
        r_hi      <= cfg_hi;
        r_cfg_err <= (cfg_lo > cfg_hi);
      end

      if (w_accept) begin
        r_res_above <= w_above && !r_cfg_err;
        r_res_below <= w_below && !r_cfg_err;
      end

      // An inverted window is meaningless, so the debouncer is held idle.
      if (r_cfg_err) begin
        r_state <= ST_OK;
        r_run   <= '0;
      end else if (w_accept) begin
        case (r_state)
          ST_OK, ST_PEND_HI, ST_PEND_LO: begin
            if (w_above) begin
              if (r_state == ST_PEND_HI && w_run_inc < DB) begin
                r_run <= w_run_inc;
              end else if ((r_state == ST_PEND_HI) || DB == RUN_W'(1)) begin
                r_state <= ST_ALARM_HI;
                r_run   <= '0;
                r_viol  <= sat_inc(r_viol);
              end else begin
                r_state <= ST_PEND_HI;
                r_run   <= RUN_W'(1);
              end
            end else if (w_below) begin
              if (r_state == ST_PEND_LO && w_run_inc < DB) begin
                r_run <= w_run_inc;
              end else if ((r_state == ST_PEND_LO) || DB == RUN_W'(1)) begin
                r_state <= ST_ALARM_LO;
                r_run   <= '0;
                r_viol  <= sat_inc(r_viol);
              end else begin
                r_state <= ST_PEND_LO;
                r_run   <= RUN_W'(1);
              end
            end else if (w_inside) begin
              r_state <= ST_OK;
              r_run   <= '0;
            end
          end
          ST_ALARM_HI: begin
            if (w_above) begin
              r_run <= '0;
            end else if (w_run_inc >= DB) begin
              r_state <= ST_OK;
              r_run   <= '0;
            end else begin
              r_run <= w_run_inc;
            end
          end
          ST_ALARM_LO: begin
            if (w_below) begin
              r_run <= '0;
            end else if (w_run_inc >= DB) begin
              r_state <= ST_OK;
              r_run   <= '0;
            end else begin
              r_run <= w_run_inc;
            end
          end
          default: begin
            r_state <= ST_OK;
            r_run   <= '0;
          end
        endcase
      end
    end
  end

  assign out_valid = r_out_valid;
  assign res_above = r_res_above;
  assign res_below = r_res_below;
  assign cfg_err   = r_cfg_err;
  assign alarm_hi  = (r_state == ST_ALARM_HI);
  assign alarm_lo  = (r_state == ST_ALARM_LO);
  assign state_o   = r_state;
  assign viol_cnt  = r_viol;

endmodule

// File: tb/tb_window_alarm_monitor.sv
// Directed bench: a default-parameter instance for the debounce/config paths
// and a DEBOUNCE=1, CNT_W=2 instance for counter saturation and async reset.
module tb_window_alarm_monitor;

  logic       clk;
  logic       rst;

  logic       cfg_wr, in_valid;
  logic [7:0] cfg_lo, cfg_hi, in_data;
  logic       in_ready, out_valid, res_above, res_below;
  logic       alarm_hi, alarm_lo, cfg_err;
  logic [2:0] state_o;
  logic [7:0] viol_cnt;

  logic       s_cfg_wr, s_in_valid;
  logic [7:0] s_cfg_lo, s_cfg_hi, s_in_data;
  logic       s_in_ready, s_out_valid, s_res_above, s_res_below;
  logic       s_alarm_hi, s_alarm_lo, s_cfg_err;
  logic [2:0] s_state_o;
  logic [1:0] s_viol_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  window_alarm_monitor dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .res_above(res_above), .res_below(res_below),
    .alarm_hi(alarm_hi), .alarm_lo(alarm_lo), .cfg_err(cfg_err),
    .state_o(state_o), .viol_cnt(viol_cnt)
  );

  window_alarm_monitor #(.W(8), .DEBOUNCE(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .cfg_wr(s_cfg_wr), .cfg_lo(s_cfg_lo), .cfg_hi(s_cfg_hi),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .res_above(s_res_above), .res_below(s_res_below),
    .alarm_hi(s_alarm_hi), .alarm_lo(s_alarm_lo), .cfg_err(s_cfg_err),
    .state_o(s_state_o), .viol_cnt(s_viol_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drives one sample into the selected instance; returns 1 time unit after
  // the accepting edge, where the results are visible.
  task automatic send(input bit sat, input logic [7:0] d);
    @(negedge clk);
    if (sat) begin s_in_valid = 1'b1; s_in_data = d; end
    else     begin in_valid   = 1'b1; in_data   = d; end
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    in_valid   = 1'b0;
  endtask

  task automatic cfg(input bit sat, input logic [7:0] lo, input logic [7:0] hi);
    @(negedge clk);
    if (sat) begin s_cfg_wr = 1'b1; s_cfg_lo = lo; s_cfg_hi = hi; end
    else     begin cfg_wr   = 1'b1; cfg_lo   = lo; cfg_hi   = hi; end
    @(posedge clk);
    #1;
    s_cfg_wr = 1'b0;
    cfg_wr   = 1'b0;
  endtask

  task automatic chk_main(input string tag, input logic [2:0] st, input logic ab,
                          input logic be, input logic [7:0] vc);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_above"}, res_above, ab);
    check({tag, "_below"}, res_below, be);
    check({tag, "_state"}, state_o, st);
    check({tag, "_ahi"},   alarm_hi, st == 3'd3);
    check({tag, "_alo"},   alarm_lo, st == 3'd4);
    check({tag, "_viol"},  viol_cnt, vc);
  endtask

  initial begin
    rst = 1'b1;
    cfg_wr = 1'b0; cfg_lo = 8'd0; cfg_hi = 8'd0; in_valid = 1'b0; in_data = 8'd0;
    s_cfg_wr = 1'b0; s_cfg_lo = 8'd0; s_cfg_hi = 8'd0; s_in_valid = 1'b0; s_in_data = 8'd0;
    #1;
    check("rst_ready", in_ready, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_state", state_o, 3'd0);
    check("rst_viol",  viol_cnt, 8'd0);
    check("rst_err",   cfg_err, 1'b0);
    #11;
    rst = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1'b1);

    // 1: default window 0..255 admits everything
    send(0, 8'd0);   chk_main("t1_s0",   3'd0, 1'b0, 1'b0, 8'd0);
    send(0, 8'd128); chk_main("t1_s128", 3'd0, 1'b0, 1'b0, 8'd0);
    send(0, 8'd255); chk_main("t1_s255", 3'd0, 1'b0, 1'b0, 8'd0);
    @(posedge clk); #1;
    check("t1_idle_valid", out_valid, 1'b0);

    // 2: window 10..200, aborted run then a full debounce into ALARM_HI
    cfg(0, 8'd10, 8'd200);
    send(0, 8'd201); chk_main("t2_a1", 3'd1, 1'b1, 1'b0, 8'd0);
    send(0, 8'd201); chk_main("t2_a2", 3'd1, 1'b1, 1'b0, 8'd0);
    @(posedge clk); #1;
    check("t2_idle_hold_above", res_above, 1'b1);
    check("t2_idle_hold_state", state_o, 3'd1);
    send(0, 8'd50);  chk_main("t2_in", 3'd0, 1'b0, 1'b0, 8'd0);
    send(0, 8'd201); chk_main("t2_b1", 3'd1, 1'b1, 1'b0, 8'd0);
    send(0, 8'd201); chk_main("t2_b2", 3'd1, 1'b1, 1'b0, 8'd0);
    send(0, 8'd201); chk_main("t2_b3", 3'd3, 1'b1, 1'b0, 8'd1);

    // 3: exit from ALARM_HI; hi itself is inside, an above sample restarts
    send(0, 8'd200); chk_main("t3_e1", 3'd3, 1'b0, 1'b0, 8'd1);
    send(0, 8'd201); chk_main("t3_rs", 3'd3, 1'b1, 1'b0, 8'd1);
    send(0, 8'd200); chk_main("t3_e2", 3'd3, 1'b0, 1'b0, 8'd1);
    send(0, 8'd200); chk_main("t3_e3", 3'd3, 1'b0, 1'b0, 8'd1);
    send(0, 8'd200); chk_main("t3_e4", 3'd0, 1'b0, 1'b0, 8'd1);

    // 4: low pending crossed over into a high run
    send(0, 8'd5);   chk_main("t4_lo",  3'd2, 1'b0, 1'b1, 8'd1);
    send(0, 8'd250); chk_main("t4_h1",  3'd1, 1'b1, 1'b0, 8'd1);
    send(0, 8'd250); chk_main("t4_h2",  3'd1, 1'b1, 1'b0, 8'd1);
    send(0, 8'd250); chk_main("t4_h3",  3'd3, 1'b1, 1'b0, 8'd2);

    // 5: inverted window written while a sample waits
    @(negedge clk);
    cfg_wr = 1'b1; cfg_lo = 8'd100; cfg_hi = 8'd50; in_valid = 1'b1; in_data = 8'd150;
    #1;
    check("t5_ready_stall", in_ready, 1'b0);
    @(posedge clk); #1;
    check("t5_no_accept", out_valid, 1'b0);
    check("t5_err", cfg_err, 1'b1);
    check("t5_state_held", state_o, 3'd3);
    cfg_wr = 1'b0;
    #1;
    check("t5_ready_back", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_main("t5_acc", 3'd0, 1'b0, 1'b0, 8'd2);
    cfg(0, 8'd10, 8'd200);
    check("t5_err_clear", cfg_err, 1'b0);

    // 6: saturation with DEBOUNCE=1, CNT_W=2
    cfg(1, 8'd10, 8'd200);
    for (int k = 1; k <= 8; k++) begin
      send(1, 8'd255);
      check("t6_ahi", s_alarm_hi, 1'b1);
      check("t6_viol", s_viol_cnt, (k > 3) ? 2'd3 : 2'(k));
      send(1, 8'd128);
      check("t6_ok", s_state_o, 3'd0);
    end
    send(1, 8'd255);
    check("t6_pre_valid", s_out_valid, 1'b1);
    check("t6_pre_ahi", s_alarm_hi, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", s_out_valid, 1'b0);
    check("t6_rst_ahi",   s_alarm_hi, 1'b0);
    check("t6_rst_above", s_res_above, 1'b0);
    check("t6_rst_viol",  s_viol_cnt, 2'd0);
    check("t6_rst_state", s_state_o, 3'd0);
    check("t6_rst_ready", s_in_ready, 1'b0);
    check("t6_rst_main_viol", viol_cnt, 8'd0);
    #10;
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
